// File: rtl/rvskid_pkg.sv
// Shared types and defaults for the rvskid_buf skid buffer.
package rvskid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } skid_state_e;

    localparam int STALL_CNT_W_DEF = 16;

endpackage

// File: rtl/rvskid_entry.sv
// One buffer slot: WIDTH-bit data register plus valid bit.
// clr drops the valid bit but leaves the data register untouched.
module rvskid_entry #(
    parameter int WIDTH = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             valid_nxt,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else begin
            valid <= valid_nxt;
            if (ld) begin
                data <= ld_data;
            end
        end
    end

endmodule

// File: rtl/rvskid_buf.sv
// Two-entry skid buffer ahead of the result register bank; in_ready is a flop.
// Optional stall counter is built only when RVSKID_STALL_CNT_EN is defined.
//
// state | meaning
// EMPTY | no entry held, out_valid=0
// ONE   | main entry held, skid free
// FULL  | main and skid held, in_ready=0
module rvskid_buf
    import rvskid_pkg::*;
#(
    parameter int WIDTH       = 63,
    parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic             main_v, skid_v;
    logic [WIDTH-1:0] main_d, skid_d;
    logic             in_fire, out_fire;
    logic             main_ld, main_from_skid, skid_ld;
    logic             ready_q;
    skid_state_e      state, state_nxt;

    assign state     = skid_state_e'({skid_v, main_v});
    assign in_ready  = ready_q;
    assign out_valid = main_v;
    assign out_data  = main_d;
    assign in_fire   = in_valid & ready_q;
    assign out_fire  = main_v & out_ready;

    always_comb begin
        state_nxt      = state;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    main_ld   = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_ld = 1'b1;
                end else if (in_fire) begin
                    skid_ld   = 1'b1;
                    state_nxt = FULL;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    rvskid_entry #(.WIDTH(WIDTH)) u_main (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .ld        (main_ld),
        .ld_data   (main_from_skid ? skid_d : in_data),
        .valid_nxt (state_nxt[0]),
        .valid     (main_v),
        .data      (main_d)
    );

    rvskid_entry #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .ld        (skid_ld),
        .ld_data   (in_data),
        .valid_nxt (state_nxt[1]),
        .valid     (skid_v),
        .data      (skid_d)
    );

    // Registered form of ~skid_v & ~rst_q: low during reset and the first cycle after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else if (flush) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= ~state_nxt[1];
        end
    end

`ifdef RVSKID_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (main_v && !out_ready && !(&stall_q)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

    a_no_illegal_state: assert property (@(posedge clk) disable iff (rst) !(skid_v && !main_v));

endmodule

// File: tb/tb_rvskid_buf.sv
// Self-checking bench for rvskid_buf: directed scenarios plus random traffic
// checked against a queue-based model of a two-deep FIFO.
module tb_rvskid_buf;

    localparam int W  = 63;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  in_data, out_data;
    logic [SW-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] hold_data;
    logic         exp_ready;
    int           exp_stall;
    bit           armed = 0;

    rvskid_buf #(.WIDTH(W), .STALL_CNT_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against model, advance model across the edge.
    task automatic cycle(input logic r, input logic f, input logic iv,
                         input logic [W-1:0] id, input logic orr);
        bit in_f, out_f, had;
        rst = r; flush = f; in_valid = iv; in_data = id; out_ready = orr;
        if (armed) begin
            check("out_valid", 64'(out_valid), 64'(q.size() > 0));
            check("out_data", 64'(out_data), 64'(hold_data));
            check("in_ready", 64'(in_ready), 64'(exp_ready));
            check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        end
        had   = q.size() > 0;
        in_f  = iv && exp_ready;
        out_f = had && orr;
        if (r) begin
            q.delete();
            hold_data = '0;
            exp_stall = 0;
        end else begin
            if (f) begin
                q.delete();
            end else begin
                if (out_f) void'(q.pop_front());
                if (in_f) q.push_back(id);
            end
`ifdef RVSKID_STALL_CNT_EN
            if (had && !orr && exp_stall < (1 << SW) - 1) exp_stall++;
`endif
        end
        if (q.size() > 0) hold_data = q[0];
        exp_ready = !r && (q.size() < 2);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic orr);
        cycle(1'b0, 1'b0, 1'b0, '0, orr);
    endtask

    initial begin
        logic         pv;
        logic [W-1:0] pd;
        logic         acc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        hold_data = '0; exp_ready = 1'b0; exp_stall = 0;
        @(negedge clk);

        // Reset then idle: first reset cycle has unknown prior state, so checks start after it.
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
        armed = 1;
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("ready_after_reset", 64'(in_ready), 64'd1);

        // Streaming 1..100 at full rate.
        for (int i = 1; i <= 100; i++) cycle(1'b0, 1'b0, 1'b1, W'(i), 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("stream_end_data", 64'(out_data), 64'd100);

        // Backpressure fill then drain.
        cycle(1'b0, 1'b0, 1'b1, {W{1'b1}}, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, W'(1), 1'b0);
        idle(1'b0);
        check("bp_full_ready", 64'(in_ready), 64'd0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush in FULL with a simultaneous offer of C.
        cycle(1'b0, 1'b0, 1'b1, W'(64'hA), 1'b0);
        cycle(1'b0, 1'b0, 1'b1, W'(64'hB), 1'b0);
        cycle(1'b0, 1'b1, 1'b1, W'(64'hC), 1'b0);
        check("flush_valid", 64'(out_valid), 64'd0);
        idle(1'b1);
        idle(1'b1);

        // Reset while FULL.
        cycle(1'b0, 1'b0, 1'b1, W'(64'hA1), 1'b0);
        cycle(1'b0, 1'b0, 1'b1, W'(64'hB2), 1'b0);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("rst_mid_data", 64'(out_data), 64'd0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Stall counter: one entry held for 20 cycles of backpressure.
        cycle(1'b0, 1'b0, 1'b1, W'(64'h55), 1'b0);
        for (int i = 0; i < 20; i++) idle(1'b0);
`ifdef RVSKID_STALL_CNT_EN
        check("stall_sat", 64'(stall_cnt), 64'd15);
`else
        check("stall_off", 64'(stall_cnt), 64'd0);
`endif
        idle(1'b1);
        idle(1'b1);

        // Random traffic; the producer holds an unaccepted payload until it is taken.
        pv = 1'b0; pd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!pv) begin
                pv = ($urandom_range(0, 3) != 0);
                pd = W'({$urandom, $urandom});
            end
            acc = pv && exp_ready;
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
                  pv, pd, ($urandom_range(0, 2) != 0));
            if (acc) pv = 1'b0;
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rvskid_buf.md
Name: rvskid_buf

Overview:
- Two-entry elastic pipeline stage (skid buffer) directly upstream of the 63-bit result register bank.
- Decouples producer valid/ready timing from the consumer so that out_ready never combinationally reaches in_ready.
- Carries a WIDTH-bit payload with full throughput of one transfer per cycle.
- Supports a synchronous flush for pipeline kill.

Parameters:
- WIDTH, 63, payload width in bits, matching the downstream register bank.
- STALL_CNT_W, 16, width of the optional stall counter.

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill; discards all buffered entries.
- in_valid  in  1  producer has a payload.
- in_ready  out  1  buffer can accept; driven directly from a flop.
- in_data  in  WIDTH  producer payload.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts this cycle.
- out_data  out  WIDTH  payload to the downstream register bank.
- stall_cnt  out  STALL_CNT_W  backpressure cycle count; see Optional Feature.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. No asynchronous paths.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage:
  - main entry: main_v, main_d. out_valid = main_v; out_data = main_d.
  - skid entry: skid_v, skid_d.
  - in_ready = ~skid_v & ~rst_q. rst_q is a flop that is 1 during reset and clears one cycle after rst deasserts.
- States, encoded from {skid_v, main_v}: EMPTY=00, ONE=01, FULL=11. The state 10 is illegal.
- EMPTY:
  - in_fire: main <= in_data; go to ONE.
- ONE:
  - in_fire & out_fire: main <= in_data; stay in ONE.
  - in_fire & ~out_fire: skid <= in_data; go to FULL.
  - ~in_fire & out_fire: go to EMPTY.
- FULL:
  - in_ready = 0, so in_fire cannot occur.
  - out_fire: main <= skid_d; skid_v <= 0; go to ONE.
  - Otherwise hold.
- Ordering: strict FIFO. Payloads are never dropped or duplicated except on flush.
- Latency: in_fire in cycle N makes out_valid visible in cycle N+1 when the buffer was EMPTY, or when it was ONE with out_fire.
- Throughput: 1 transfer/cycle sustained while out_ready=1.
- Flush:
  - At the next edge main_v and skid_v clear and the state goes to EMPTY.
  - Flush beats in_fire and out_fire in the same cycle: data accepted that cycle is discarded.
  - Data registers hold their values.
- Reset:
  - At the next edge: main_v=0, skid_v=0, main_d=0, skid_d=0, stall_cnt=0.
  - out_valid=0, out_data=0.
  - in_ready=0 while rst=1 and for the first cycle after release, then 1.
  - Reset during FULL discards both entries identically.
- Priority: rst over flush over handshake.
- X-safety: out_data must be 0 after reset, never X.
- Assertions:
  - state 10 never occurs.
  - in_valid with in_ready=0 must hold in_data stable until accepted; this is a producer rule and is checked by the bench.

Optional Feature:
- Macro: RVSKID_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 each cycle with out_valid & ~out_ready.
  - Saturates at all-ones.
  - Clears on rst. Not cleared by flush.
- Undefined:
  - stall_cnt is tied to 0 and no counter flops are built.
  - All other behaviour is identical.

Decomposition:
- Package rvskid_pkg:
  - typedef enum logic [1:0] skid_state_e {EMPTY=2'b00, ONE=2'b01, FULL=2'b11}.
  - localparam STALL_CNT_W_DEF = 16.
- One sub-module, rvskid_entry: WIDTH-bit data register with valid bit, load enable, synchronous active-high reset and clear. It is instantiated twice (main, skid).

Test Plan:
- Reset then idle: rst=1 for 3 cycles, then release -> out_valid=0, out_data=0, in_ready=0 during reset and for 1 cycle after, then 1; stall_cnt=0.
- Streaming: out_ready=1, in_valid=1 with in_data 1,2,...,100 back-to-back -> out_data 1..100 in order, one per cycle from cycle 1, in_ready never drops, final state EMPTY.
- Backpressure fill: out_ready=0, offer 0x7FFF_FFFF_FFFF_FFFF then 0x1 -> first goes to main, second to skid, in_ready=0; raise out_ready -> outputs 0x7FFF_FFFF_FFFF_FFFF, then 0x1, then out_valid=0.
- Flush with simultaneous accept: FULL holding A,B; pulse flush with in_valid=1, data C -> next cycle out_valid=0, in_ready=1, C never appears at the output.
- Reset mid-operation: FULL holding A,B; assert rst 1 cycle -> out_valid=0, out_data=0, in_ready=0 for 2 cycles, neither A nor B emitted.
- Stall counter (RVSKID_STALL_CNT_EN, STALL_CNT_W=4): hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt reads 15 and holds; with the macro undefined it reads 0.
